// File: rtl/imem_loader.sv
// imem_loader: instruction memory for the single-cycle core plus its boot loader.
// Holds the core in reset while a little-endian byte image is written from word 0,
// then releases the core and serves fetches combinationally from the word array.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   pc / instr        core fetch address in, instruction word out (combinational)
//   ld_valid/ld_data/ld_last/ld_ready   byte-wide valid/ready image load port
//   core_reset        reset for the core (registered)
//   load_done         image loaded, core running (registered)
//   load_err          image overflowed the array, sticky until reset (registered)
//   loaded_words      words written since the last reset
module imem_loader #(
    parameter logic [31:0] BootVector = 32'h0000_0000,
    parameter int unsigned Depth      = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                pc,
    output logic [31:0]                instr,
    input  logic                       ld_valid,
    input  logic [7:0]                 ld_data,
    input  logic                       ld_last,
    output logic                       ld_ready,
    output logic                       core_reset,
    output logic                       load_done,
    output logic                       load_err,
    output logic [$clog2(Depth):0]     loaded_words
);

    localparam int unsigned AW        = $clog2(Depth);
    localparam int unsigned LW        = AW + 1;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] MEM_BYTES = 32'(Depth * 4);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_ERR  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     lane_q, lane_d;
    logic [31:0]    shadow_q, shadow_d;
    logic [LW-1:0]  loaded_words_q, loaded_words_d;
    logic           ld_ready_q, ld_ready_d;
    logic           core_reset_q, core_reset_d;
    logic           load_done_q, load_done_d;
    logic           load_err_q, load_err_d;

    logic [31:0]    mem [Depth];
    logic           mem_we;
    logic [AW-1:0]  mem_waddr;
    logic [31:0]    mem_wdata;
    logic [31:0]    word;
    logic [31:0]    offset;

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_LOAD;
            lane_q         <= 2'd0;
            shadow_q       <= 32'd0;
            loaded_words_q <= '0;
            ld_ready_q     <= 1'b1;
            core_reset_q   <= 1'b1;
            load_done_q    <= 1'b0;
            load_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            lane_q         <= lane_d;
            shadow_q       <= shadow_d;
            loaded_words_q <= loaded_words_d;
            ld_ready_q     <= ld_ready_d;
            core_reset_q   <= core_reset_d;
            load_done_q    <= load_done_d;
            load_err_q     <= load_err_d;
        end
    end

    // Word array write port; contents survive reset on purpose
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Next-state, byte assembly and word write control
    always_comb begin
        state_d        = state_q;
        lane_d         = lane_q;
        shadow_d       = shadow_q;
        loaded_words_d = loaded_words_q;
        mem_we         = 1'b0;
        mem_waddr      = loaded_words_q[AW-1:0];
        mem_wdata      = 32'd0;
        word           = 32'd0;

        case (state_q)
            S_LOAD: begin
                if (ld_valid && ld_ready_q) begin
                    if (loaded_words_q == LW'(Depth)) begin
                        // Byte would start word index Depth: drop it and trap
                        state_d = S_ERR;
                    end else begin
                        // Lane 0 starts a fresh word so unsent upper bytes read as zero
                        word = (lane_q == 2'd0) ? 32'd0 : shadow_q;
                        word[{lane_q, 3'b000} +: 8] = ld_data;
                        shadow_d = word;
                        lane_d   = lane_q + 2'd1;
                        if (lane_q == 2'd3 || ld_last) begin
                            mem_we         = 1'b1;
                            mem_wdata      = word;
                            loaded_words_d = loaded_words_q + LW'(1);
                            lane_d         = 2'd0;
                        end
                        if (ld_last) begin
                            state_d = S_RUN;
                        end
                    end
                end
            end
            S_RUN:   state_d = S_RUN;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_LOAD;
        endcase

        ld_ready_d   = (state_d != S_RUN);
        core_reset_d = (state_d != S_RUN);
        load_done_d  = (state_d == S_RUN);
        load_err_d   = (state_d == S_ERR);
    end

    // Fetch path: byte offset from the boot vector, out-of-range reads return NOP
    always_comb begin
        offset = pc - BootVector;
        instr  = NOP;
        if (state_q == S_RUN && offset < MEM_BYTES) begin
            instr = mem[offset[AW+1:2]];
        end
    end

    assign ld_ready     = ld_ready_q;
    assign core_reset   = core_reset_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign loaded_words = loaded_words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: dut0 (Depth 4, boot vector 0) and
// dut1 (Depth 16, boot vector 0x8000_0000) share every input.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;

    logic [31:0] instr0, instr1;
    logic        ld_ready0, ld_ready1;
    logic        core_reset0, core_reset1;
    logic        load_done0, load_done1;
    logic        load_err0, load_err1;
    logic [2:0]  loaded_words0;
    logic [4:0]  loaded_words1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_loader #(.BootVector(32'h0000_0000), .Depth(4)) dut0 (
        .clk(clk), .reset(reset), .pc(pc), .instr(instr0),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready0), .core_reset(core_reset0), .load_done(load_done0),
        .load_err(load_err0), .loaded_words(loaded_words0)
    );

    imem_loader #(.BootVector(32'h8000_0000), .Depth(16)) dut1 (
        .clk(clk), .reset(reset), .pc(pc), .instr(instr1),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready1), .core_reset(core_reset1), .load_done(load_done1),
        .load_err(load_err1), .loaded_words(loaded_words1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the byte is taken on the following posedge
    task automatic send(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_data  = b;
        ld_last  = last;
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic fetch0(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        pc = addr;
        #1;
        chk(tag, instr0, exp);
    endtask

    logic [7:0] img1 [8];
    logic [7:0] img2 [6];

    initial begin
        reset = 1'b1; pc = 32'd0; ld_valid = 1'b0; ld_data = 8'd0; ld_last = 1'b0;
        img1 = '{8'h13, 8'h05, 8'ha0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        img2 = '{8'hef, 8'hbe, 8'had, 8'hde, 8'h37, 8'h12};
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_core_reset", 32'(core_reset0), 32'd1);
        chk("rst_load_done", 32'(load_done0), 32'd0);
        chk("rst_load_err", 32'(load_err0), 32'd0);
        chk("rst_loaded_words", 32'(loaded_words0), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready0), 32'd1);
        fetch0("rst_instr_nop", 32'd0, 32'h0000_0013);

        // 8-byte image, last on byte 8
        for (int i = 0; i < 7; i++) send(img1[i], 1'b0);
        chk("img1_pre_core_reset", 32'(core_reset0), 32'd1);
        chk("img1_pre_words", 32'(loaded_words0), 32'd1);
        send(img1[7], 1'b1);
        chk("img1_words", 32'(loaded_words0), 32'd2);
        chk("img1_load_done", 32'(load_done0), 32'd1);
        chk("img1_core_reset", 32'(core_reset0), 32'd0);
        chk("img1_ld_ready", 32'(ld_ready0), 32'd0);
        fetch0("img1_pc0", 32'd0, 32'h00a0_0513);
        fetch0("img1_pc4", 32'd4, 32'h0010_0593);
        fetch0("img1_pc6", 32'd6, 32'h0010_0593);
        fetch0("img1_pc16_oor", 32'd16, 32'h0000_0013);

        // Reset during RUN
        pulse_reset();
        chk("runrst_core_reset", 32'(core_reset0), 32'd1);
        chk("runrst_load_done", 32'(load_done0), 32'd0);
        chk("runrst_words", 32'(loaded_words0), 32'd0);

        // 6-byte image, partial final word
        for (int i = 0; i < 6; i++) send(img2[i], i == 5);
        chk("img2_words", 32'(loaded_words0), 32'd2);
        fetch0("img2_pc0", 32'd0, 32'hdead_beef);
        fetch0("img2_pc4", 32'd4, 32'h0000_1237);

        // Reset partway through a word, then a fresh 4-byte image
        pulse_reset();
        send(8'haa, 1'b0); send(8'hbb, 1'b0); send(8'hcc, 1'b0);
        pulse_reset();
        chk("midrst_words", 32'(loaded_words0), 32'd0);
        send(8'h93, 1'b0); send(8'h00, 1'b0); send(8'hf0, 1'b0); send(8'h0f, 1'b1);
        chk("fresh_words", 32'(loaded_words0), 32'd1);
        fetch0("fresh_pc0", 32'd0, 32'h0ff0_0093);
        fetch0("fresh_pc4_kept", 32'd4, 32'h0000_1237);

        // 12-byte image with random 0-5 cycle gaps
        pulse_reset();
        for (int i = 0; i < 12; i++) begin
            send(8'(8'h10 + i), i == 11);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        chk("gap_words", 32'(loaded_words0), 32'd3);
        fetch0("gap_pc0", 32'd0, 32'h1312_1110);
        fetch0("gap_pc4", 32'd4, 32'h1716_1514);
        fetch0("gap_pc8", 32'd8, 32'h1b1a_1918);

        // Overflow: 17 bytes into a 4-word array
        pulse_reset();
        for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 1'b0);
        chk("ovf_pre_err", 32'(load_err0), 32'd0);
        chk("ovf_pre_words", 32'(loaded_words0), 32'd4);
        send(8'h30, 1'b0);
        chk("ovf_err", 32'(load_err0), 32'd1);
        chk("ovf_core_reset", 32'(core_reset0), 32'd1);
        chk("ovf_ld_ready", 32'(ld_ready0), 32'd1);
        chk("ovf_load_done", 32'(load_done0), 32'd0);
        chk("ovf_words", 32'(loaded_words0), 32'd4);
        fetch0("ovf_instr_nop", 32'd0, 32'h0000_0013);
        send(8'h31, 1'b1);
        chk("ovf_sticky", 32'(load_err0), 32'd1);
        chk("ovf_last_ignored", 32'(load_done0), 32'd0);

        // One-byte image overwrites word 0 only; words 1..3 keep the overflow data
        pulse_reset();
        chk("ovf_rst_err", 32'(load_err0), 32'd0);
        send(8'haa, 1'b1);
        chk("one_words", 32'(loaded_words0), 32'd1);
        fetch0("one_pc0_partial", 32'd0, 32'h0000_00aa);
        fetch0("ovf_mem1", 32'd4, 32'h2726_2524);
        fetch0("ovf_mem2", 32'd8, 32'h2b2a_2928);
        fetch0("ovf_mem3", 32'd12, 32'h2f2e_2d2c);

        // Non-zero boot vector on dut1
        pulse_reset();
        send(8'h13, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b1);
        chk("bv_load_done", 32'(load_done1), 32'd1);
        chk("bv_words", 32'(loaded_words1), 32'd1);
        pc = 32'h8000_0000; #1;
        chk("bv_pc_base", instr1, 32'h0000_0013);
        pc = 32'h7fff_fffc; #1;
        chk("bv_pc_below", instr1, 32'h0000_0013);
        pc = 32'h8000_1000; #1;
        chk("bv_pc_far", instr1, 32'h0000_0013);
        pc = 32'h8000_0000; #1;
        chk("bv_dut0_highpc", instr0, 32'h0000_0013);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound on run time
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
